// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding and counter width for the bus address decoder
package bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Wide enough for the largest allowed TIMEOUT (255)
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DECODE = ST_DECODE,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } state_t;

endpackage

// File: rtl/bus_addr_match.sv
// rtl/bus_addr_match.sv - raw per-region address hit vector, no priority
module bus_addr_match #(
  parameter int                   AW    = 8,
  parameter int                   N_SLV = 2,
  parameter logic [N_SLV*AW-1:0]  BASE  = {8'h20, 8'h00},
  parameter logic [N_SLV*AW-1:0]  LAST  = {8'h3F, 8'h1F}
) (
  input  logic [AW-1:0]    addr,
  output logic [N_SLV-1:0] hit
);

  // A region with BASE above LAST is treated as disabled and never hits
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SLV; i++) begin
      hit[i] = (BASE[i*AW +: AW] <= LAST[i*AW +: AW]) &&
               (addr >= BASE[i*AW +: AW]) &&
               (addr <= LAST[i*AW +: AW]);
    end
  end

endmodule

// File: rtl/bus_addr_dec.sv
// rtl/bus_addr_dec.sv - request/decode/access/response bus address decoder with ack timeout
module bus_addr_dec
  import bus_pkg::*;
#(
  parameter int                   AW      = 8,
  parameter int                   N_SLV   = 2,
  parameter logic [N_SLV*AW-1:0]  BASE    = {8'h20, 8'h00},
  parameter logic [N_SLV*AW-1:0]  LAST    = {8'h3F, 8'h1F},
  parameter int                   TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_req,
  input  logic [AW-1:0]    m_addr,
  input  logic [N_SLV-1:0] s_ack,
  output logic [N_SLV-1:0] s_sel,
  output logic             m_ack,
  output logic             m_err,
  output logic             busy
);

  state_t            state, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [N_SLV-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [N_SLV-1:0]  hit;
  logic [N_SLV-1:0]  win;
  logic              ack_sel;

  bus_addr_match #(
    .AW    (AW),
    .N_SLV (N_SLV),
    .BASE  (BASE),
    .LAST  (LAST)
  ) u_match (
    .addr (addr_q),
    .hit  (hit)
  );

  // Overlapping regions resolve to the lowest index: scan downwards so the last write wins
  always_comb begin
    win = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

  // Only the currently selected slave can complete the access
  assign ack_sel = |(s_ack & sel_q);

  // Next-state and datapath updates; ack is checked before timeout so a last-cycle ack succeeds
  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state)
      S_IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        if (|hit) begin
          sel_d   = win;
          err_d   = 1'b0;
          state_d = S_ACCESS;
        end else begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_ACCESS: begin
        if (ack_sel) begin
          sel_d   = '0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            sel_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Latched address, slave select, timeout counter and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign s_sel = sel_q;
  assign m_ack = (state == S_RESP);
  assign m_err = (state == S_RESP) & err_q;
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_bus_addr_dec.sv
// tb/tb_bus_addr_dec.sv - randomized self-checking bench for bus_addr_dec against a transaction model
module tb_bus_addr_dec;

  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic       m_req;
  logic [7:0] m_addr;
  logic [1:0] s_ack;
  logic       which;

  logic [1:0] sel0, sel1, o_sel;
  logic       ack0, ack1, o_ack;
  logic       err0, err1, o_err;
  logic       busy0, busy1, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] base_m [2][2];
  logic [7:0] last_m [2][2];

  bus_addr_dec #(
    .AW(8), .N_SLV(2), .BASE({8'h20, 8'h00}), .LAST({8'h3F, 8'h1F}), .TIMEOUT(TO)
  ) u_dut0 (
    .clk(clk), .reset(reset), .m_req(m_req & ~which), .m_addr(m_addr), .s_ack(s_ack),
    .s_sel(sel0), .m_ack(ack0), .m_err(err0), .busy(busy0)
  );

  bus_addr_dec #(
    .AW(8), .N_SLV(2), .BASE({8'h00, 8'h00}), .LAST({8'hFF, 8'h0F}), .TIMEOUT(TO)
  ) u_dut1 (
    .clk(clk), .reset(reset), .m_req(m_req & which), .m_addr(m_addr), .s_ack(s_ack),
    .s_sel(sel1), .m_ack(ack1), .m_err(err1), .busy(busy1)
  );

  assign o_sel  = which ? sel1  : sel0;
  assign o_ack  = which ? ack1  : ack0;
  assign o_err  = which ? err1  : err0;
  assign o_busy = which ? busy1 : busy0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: region i hits when base<=a<=last; the lowest hitting index wins; -1 on miss
  function automatic int model_win(input logic m, input logic [7:0] a);
    int r;
    r = -1;
    for (int i = 1; i >= 0; i--) begin
      if (base_m[m][i] <= last_m[m][i] && a >= base_m[m][i] && a <= last_m[m][i]) r = i;
    end
    return r;
  endfunction

  // One full transaction: ack_at is the ACCESS cycle (1-based) in which the selected slave acks
  task automatic run_txn(input logic [7:0] a, input int ack_at, input bit hold);
    int         w;
    int         len;
    bit         exp_err;
    logic [1:0] oh;
    w = model_win(which, a);
    @(negedge clk);
    m_req  = 1'b1;
    m_addr = a;
    s_ack  = 2'b00;
    @(negedge clk);
    if (!hold) m_req = 1'b0;
    check("decode_busy", 32'(o_busy), 32'd1);
    check("decode_sel", 32'(o_sel), 32'd0);
    check("decode_ack", 32'(o_ack), 32'd0);
    s_ack = 2'($urandom);
    if (w >= 0) begin
      oh      = 2'(1 << w);
      exp_err = (ack_at > TO);
      len     = exp_err ? TO : ack_at;
      for (int j = 1; j <= len; j++) begin
        @(negedge clk);
        check("access_sel", 32'(o_sel), 32'(oh));
        check("access_ack", 32'(o_ack), 32'd0);
        s_ack = 2'($urandom) & ~oh;
        if (j == ack_at) s_ack = s_ack | oh;
      end
    end else begin
      exp_err = 1'b1;
    end
    @(negedge clk);
    s_ack = 2'b00;
    check("resp_ack", 32'(o_ack), 32'd1);
    check("resp_err", 32'(o_err), 32'(exp_err));
    check("resp_sel", 32'(o_sel), 32'd0);
    check("resp_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_ack", 32'(o_ack), 32'd0);
  endtask

  initial begin
    logic [7:0] edge_addrs [8];
    base_m[0][0] = 8'h00; last_m[0][0] = 8'h1F;
    base_m[0][1] = 8'h20; last_m[0][1] = 8'h3F;
    base_m[1][0] = 8'h00; last_m[1][0] = 8'h0F;
    base_m[1][1] = 8'h00; last_m[1][1] = 8'hFF;
    edge_addrs = '{8'h00, 8'h1F, 8'h20, 8'h3F, 8'h40, 8'hFF, 8'h0F, 8'h10};

    which  = 1'b0;
    m_req  = 1'b0;
    m_addr = 8'h00;
    s_ack  = 2'b00;
    reset  = 1'b1;
    #3;
    check("rst_sel", 32'(sel0), 32'd0);
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_txn(8'h00, 1, 1'b0);
    run_txn(8'h3F, 3, 1'b0);
    run_txn(8'h40, 1, 1'b0);
    run_txn(8'h1F, 9, 1'b0);
    run_txn(8'h1F, TO, 1'b0);

    // Asynchronous reset in the middle of ACCESS abandons the transaction
    @(negedge clk);
    m_req  = 1'b1;
    m_addr = 8'h20;
    @(negedge clk);
    m_req = 1'b0;
    @(negedge clk);
    check("pre_rst_sel", 32'(sel0), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sel", 32'(sel0), 32'd0);
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_ack", 32'(ack0), 32'd0);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_ack", 32'(ack0), 32'd0);
      check("post_rst_busy", 32'(busy0), 32'd0);
    end
    run_txn(8'h20, 1, 1'b0);

    // m_req held high: the next transaction starts only after the IDLE cycle
    run_txn(8'h00, 2, 1'b1);
    @(negedge clk);
    m_req = 1'b0;
    check("hold_restart_busy", 32'(busy0), 32'd1);
    check("hold_restart_sel", 32'(sel0), 32'd0);
    @(negedge clk);
    check("hold_access_sel", 32'(sel0), 32'd1);
    s_ack = 2'b01;
    @(negedge clk);
    s_ack = 2'b00;
    check("hold_resp_ack", 32'(ack0), 32'd1);
    check("hold_resp_err", 32'(err0), 32'd0);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy0), 32'd0);

    // Overlapping map: lowest index wins
    which = 1'b1;
    run_txn(8'h05, 1, 1'b0);
    run_txn(8'h50, 2, 1'b0);
    run_txn(8'h0C, 6, 1'b0);
    which = 1'b0;

    for (int n = 0; n < 40; n++) begin
      logic [7:0] a;
      which = 1'($urandom);
      a = ($urandom_range(0, 1) == 0) ? edge_addrs[$urandom_range(0, 7)] : 8'($urandom);
      run_txn(a, $urandom_range(1, 6), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
